// File: rtl/exec_unit_if.sv
// exec_unit_if: execute-stage bus (master drives start/op/operands/destReg; slave returns busy/done/zero and the bank write port readWrite/writeReg/writeData)
interface exec_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic start;
  logic [2:0] op;
  logic [DATA_WIDTH-1:0] dataReadA;
  logic [DATA_WIDTH-1:0] dataReadB;
  logic [REG_ADDR_WIDTH-1:0] destReg;
  logic busy;
  logic done;
  logic zero;
  logic readWrite;
  logic [REG_ADDR_WIDTH-1:0] writeReg;
  logic [DATA_WIDTH-1:0] writeData;
  modport master (
    output start, op, dataReadA, dataReadB, destReg,
    input busy, done, zero, readWrite, writeReg, writeData
  );
  modport slave (
    input start, op, dataReadA, dataReadB, destReg,
    output busy, done, zero, readWrite, writeReg, writeData
  );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: execute stage (clock, clear async reset, bus slave); 1-cycle ADD/SUB/AND/OR/SLT, 32-step MUL/DIVU/REMU, result to bank write port
module exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic clock,
  input logic clear,
  exec_unit_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [2:0] op_r;
  logic [DATA_WIDTH-1:0] b_r, acc, lo, mc, acc_n, lo_n, mc_n, simple, iter_res;
  logic [REG_ADDR_WIDTH-1:0] dest_r;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH:0] sh;
  logic ge, last, iter, is_mul;
  assign iter = bus.op[2] & (bus.op[1] | bus.op[0]);
  assign is_mul = op_r == 3'b101;
  assign last = cnt == CW'(DATA_WIDTH - 1);
  always_comb begin
    simple = bus.op == 3'b000 ? bus.dataReadA + bus.dataReadB :
             bus.op == 3'b001 ? bus.dataReadA - bus.dataReadB :
             bus.op == 3'b010 ? bus.dataReadA & bus.dataReadB :
             bus.op == 3'b011 ? bus.dataReadA | bus.dataReadB :
             {{(DATA_WIDTH-1){1'b0}}, $signed(bus.dataReadA) < $signed(bus.dataReadB)};
    sh = {acc, lo[DATA_WIDTH-1]};
    ge = sh >= {1'b0, b_r};
    acc_n = is_mul ? acc + (lo[0] ? mc : '0) : ge ? sh[DATA_WIDTH-1:0] - b_r : sh[DATA_WIDTH-1:0];
    lo_n = is_mul ? lo >> 1 : {lo[DATA_WIDTH-2:0], ge};
    mc_n = mc << 1;
    iter_res = op_r == 3'b110 ? lo_n : acc_n;
  end
  always_ff @(posedge clock or posedge clear)
    if (clear) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.start ? (iter ? CALC : DONE) : IDLE) :
              state == CALC ? (last ? DONE : CALC) : IDLE;
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.readWrite = bus.done && bus.writeReg != '0;
    bus.zero = bus.done && bus.writeData == '0;
  end
  always_ff @(posedge clock or posedge clear)
    if (clear) begin
      op_r <= '0;
      b_r <= '0;
      dest_r <= '0;
      cnt <= '0;
      acc <= '0;
      lo <= '0;
      mc <= '0;
      bus.writeData <= '0;
      bus.writeReg <= '0;
    end else if (state == IDLE && bus.start) begin
      op_r <= bus.op;
      b_r <= bus.dataReadB;
      dest_r <= bus.destReg;
      cnt <= '0;
      acc <= '0;
      mc <= bus.dataReadA;
      lo <= bus.op == 3'b101 ? bus.dataReadB : bus.dataReadA;
      if (!iter) begin
        bus.writeData <= simple;
        bus.writeReg <= bus.destReg;
      end
    end else if (state == CALC) begin
      acc <= acc_n;
      lo <= lo_n;
      mc <= mc_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        bus.writeData <= iter_res;
        bus.writeReg <= dest_r;
      end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed self-checking bench for exec_unit
module tb_exec_unit;
  logic clock = 1'b0;
  logic clear = 1'b1;
  int total = 0;
  int passed = 0;
  int rw_seen;
  always #5 clock = ~clock;
  exec_unit_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus();
  exec_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (.clock(clock), .clear(clear), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] d, input logic [31:0] exp, input int lat, input bit noise);
    int n;
    @(negedge clock);
    bus.start = 1'b1;
    bus.op = op;
    bus.dataReadA = a;
    bus.dataReadB = b;
    bus.destReg = d;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.dataReadA = ~a;
    bus.dataReadB = ~b;
    bus.destReg = ~d;
    n = 1;
    while (!bus.done && n < 40) begin
      bus.start = noise && n >= 3 && n <= 6;
      bus.op = 3'b000;
      @(posedge clock);
      #1;
      n++;
    end
    bus.start = 1'b0;
    check($sformatf("%s latency", tag), 32'(n), 32'(lat));
    check($sformatf("%s done", tag), 32'(bus.done), 32'd1);
    check($sformatf("%s busy", tag), 32'(bus.busy), 32'd1);
    check($sformatf("%s data", tag), bus.writeData, exp);
    check($sformatf("%s reg", tag), 32'(bus.writeReg), 32'(d));
    check($sformatf("%s we", tag), 32'(bus.readWrite), 32'(d != 5'd0));
    check($sformatf("%s zero", tag), 32'(bus.zero), 32'(exp == 32'd0));
    @(posedge clock);
    #1;
    check($sformatf("%s done drop", tag), 32'(bus.done), 32'd0);
    check($sformatf("%s we drop", tag), 32'(bus.readWrite), 32'd0);
    check($sformatf("%s idle", tag), 32'(bus.busy), 32'd0);
    check($sformatf("%s hold", tag), bus.writeData, exp);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.dataReadA = '0;
    bus.dataReadB = '0;
    bus.destReg = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst zero", 32'(bus.zero), 32'd0);
    check("rst we", 32'(bus.readWrite), 32'd0);
    check("rst reg", 32'(bus.writeReg), 32'd0);
    check("rst data", bus.writeData, 32'd0);
    clear = 1'b0;
    run("add", 3'b000, 32'd5, 32'd7, 5'd3, 32'd12, 1, 1'b0);
    run("sub0", 3'b001, 32'd3, 32'd3, 5'd4, 32'd0, 1, 1'b0);
    run("slt", 3'b100, 32'hFFFFFFFE, 32'd1, 5'd6, 32'd1, 1, 1'b0);
    run("slt neg", 3'b100, 32'd5, 32'hFFFFFFFD, 5'd6, 32'd0, 1, 1'b0);
    run("sub wrap", 3'b001, 32'd0, 32'd1, 5'd7, 32'hFFFFFFFF, 1, 1'b0);
    run("and", 3'b010, 32'hF0F0FF00, 32'h0FF0F0F0, 5'd8, 32'h00F0F000, 1, 1'b0);
    run("or", 3'b011, 32'hF0F00000, 32'h0000000F, 5'd9, 32'hF0F0000F, 1, 1'b0);
    run("mul", 3'b101, 32'h00010003, 32'h00020005, 5'd10, 32'h000B000F, 33, 1'b1);
    run("mul max", 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'd1, 33, 1'b0);
    run("divu", 3'b110, 32'd100, 32'd7, 5'd12, 32'd14, 33, 1'b0);
    run("remu", 3'b111, 32'd100, 32'd7, 5'd13, 32'd2, 33, 1'b0);
    run("divu0", 3'b110, 32'd9, 32'd0, 5'd14, 32'hFFFFFFFF, 33, 1'b0);
    run("remu0", 3'b111, 32'd9, 32'd0, 5'd15, 32'd9, 33, 1'b0);
    run("divu big", 3'b110, 32'hFFFFFFFF, 32'd16, 5'd16, 32'h0FFFFFFF, 33, 1'b1);
    run("remu big", 3'b111, 32'hFFFFFFFF, 32'd16, 5'd17, 32'h0000000F, 33, 1'b0);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op = 3'b101;
    bus.dataReadA = 32'h00010003;
    bus.dataReadB = 32'h00020005;
    bus.destReg = 5'd20;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort we", 32'(bus.readWrite), 32'd0);
    check("abort data", bus.writeData, 32'd0);
    check("abort reg", 32'(bus.writeReg), 32'd0);
    @(posedge clock);
    #2;
    clear = 1'b0;
    run("post clr add", 3'b000, 32'd1, 32'd1, 5'd5, 32'd2, 1, 1'b0);
    rw_seen = 0;
    repeat (36) begin
      @(posedge clock);
      #1;
      rw_seen += int'(bus.readWrite);
    end
    check("ghost write", 32'(rw_seen), 32'd0);
    run("r0 add", 3'b000, 32'd1, 32'd2, 5'd0, 32'd3, 1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
